// File: rtl/proc_pkg.sv
// proc_pkg: fault codes and sequencer state type shared by the stage sequencer
package proc_pkg;
  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
  localparam logic [1:0] FAULT_MEMERR  = 2'b10;
  typedef enum logic [1:0] {IDLE, ACTIVE, FAULT} seq_state_t;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: free-wrapping up counter with enable and synchronous clear
module wrap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= clr ? '0 : en ? q + W'(1) : q;
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle instruction stage controller with memory waits, step mode and sticky fault
module stage_sequencer
  import proc_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int MEM_STAGE  = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             Step_Mode,
  input  logic             Step,
  input  logic             Mem_Access,
  input  logic             MEM_MFC,
  input  logic             MEM_ERROR,
  output logic [3:0]       Stage,
  output logic             Stage_Done,
  output logic             Mem_Req,
  output logic             Busy,
  output logic             Fault,
  output logic [1:0]       Fault_Code,
  output logic [CNT_W-1:0] Instr_Count,
  output logic [CNT_W-1:0] Cycle_Count
);
  seq_state_t state, state_n;
  logic [3:0] stage, stage_n;
  logic [1:0] code, code_n;
  logic [7:0] wait_cnt;
  logic mem_bound, err, tmo, done, last, start, go;
  assign mem_bound = state == ACTIVE && (stage == 4'd1 || (stage == 4'(MEM_STAGE) && Mem_Access));
  assign err       = mem_bound && MEM_ERROR;
  assign tmo       = mem_bound && !MEM_MFC && wait_cnt == 8'(TIMEOUT - 1);
  assign done      = state == ACTIVE && (!mem_bound || (MEM_MFC && !MEM_ERROR));
  assign last      = done && stage == 4'(NUM_STAGES);
  assign start     = Step_Mode ? Step : Run;
  assign go        = !Step_Mode && Run;
  always_comb begin
    state_n = state;
    stage_n = stage;
    code_n  = code;
    if (state == IDLE && start) begin
      state_n = ACTIVE;
      stage_n = 4'd1;
    end else if (err || tmo) begin
      state_n = FAULT;
      stage_n = 4'd0;
      code_n  = err ? FAULT_MEMERR : FAULT_TIMEOUT;
    end else if (last) begin
      state_n = go ? ACTIVE : IDLE;
      stage_n = go ? 4'd1 : 4'd0;
    end else if (done) begin
      stage_n = stage + 4'd1;
    end
  end
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state <= IDLE;
      stage <= 4'd0;
      code  <= FAULT_NONE;
    end else begin
      state <= state_n;
      stage <= stage_n;
      code  <= code_n;
    end
  end
  wrap_counter #(.W(8)) u_wait (
    .clk(Clock), .clr(!Reset_n || state != ACTIVE || done), .en(mem_bound && !MEM_MFC), .q(wait_cnt)
  );
  wrap_counter #(.W(CNT_W)) u_instr (
    .clk(Clock), .clr(!Reset_n), .en(last), .q(Instr_Count)
  );
  wrap_counter #(.W(CNT_W)) u_cycle (
    .clk(Clock), .clr(!Reset_n), .en(state == ACTIVE), .q(Cycle_Count)
  );
  assign Stage      = stage;
  assign Stage_Done = done;
  assign Mem_Req    = mem_bound;
  assign Busy       = state == ACTIVE;
  assign Fault      = state == FAULT;
  assign Fault_Code = code;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed and randomized checks of stage_sequencer against a cycle-level reference model
module tb_stage_sequencer;
  localparam int N = 5, MS = 4, T = 16, W = 8;
  logic clk = 0, rn = 0, run = 0, sm = 0, st = 0, ma = 0, mfc = 0, merr = 0;
  logic [3:0] stage;
  logic sd, mreq, busy, fault;
  logic [1:0] fc;
  logic [W-1:0] ic, cc;
  int vectors = 0, miscompares = 0;
  int m_state = 0, m_stage = 0, m_wait = 0, m_code = 0;
  logic [W-1:0] m_ic = 0, m_cc = 0, saved;
  int n, k;
  always #5 clk = ~clk;
  stage_sequencer #(.NUM_STAGES(N), .MEM_STAGE(MS), .TIMEOUT(T), .CNT_W(W)) dut (
    .Clock(clk), .Reset_n(rn), .Run(run), .Step_Mode(sm), .Step(st), .Mem_Access(ma),
    .MEM_MFC(mfc), .MEM_ERROR(merr), .Stage(stage), .Stage_Done(sd), .Mem_Req(mreq),
    .Busy(busy), .Fault(fault), .Fault_Code(fc), .Instr_Count(ic), .Cycle_Count(cc)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic i_rn, i_run, i_sm, i_st, i_ma, i_mfc, i_err, input bit do_comb);
    bit mb, dn;
    rn = i_rn; run = i_run; sm = i_sm; st = i_st; ma = i_ma; mfc = i_mfc; merr = i_err;
    #1;
    mb = m_state == 1 && (m_stage == 1 || (m_stage == MS && i_ma));
    dn = m_state == 1 && (!mb || (i_mfc && !i_err));
    if (do_comb) begin
      chk("stage_done", sd, dn);
      chk("mem_req", mreq, mb);
    end
    if (!i_rn) begin
      m_state = 0; m_stage = 0; m_wait = 0; m_code = 0; m_ic = 0; m_cc = 0;
    end else if (m_state == 0) begin
      if (i_sm ? i_st : i_run) begin m_state = 1; m_stage = 1; m_wait = 0; end
    end else if (m_state == 1) begin
      m_cc++;
      if (mb && i_err) begin m_state = 2; m_stage = 0; m_code = 2; end
      else if (mb && !i_mfc && m_wait == T - 1) begin m_state = 2; m_stage = 0; m_code = 1; end
      else if (dn) begin
        m_wait = 0;
        if (m_stage == N) begin
          m_ic++;
          if (!i_sm && i_run) m_stage = 1;
          else begin m_state = 0; m_stage = 0; end
        end else m_stage++;
      end else m_wait++;
    end
    @(posedge clk);
    #1;
    chk("stage", stage, m_stage);
    chk("busy", busy, m_state == 1);
    chk("fault", fault, m_state == 2);
    chk("fault_code", fc, m_code);
    chk("instr_count", ic, m_ic);
    chk("cycle_count", cc, m_cc);
  endtask
  initial begin
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 1, 0, 1);
    chk("reset_stage", stage, 0);
    for (int i = 1; i <= 11; i++) begin
      tick(1, 1, 0, 0, 0, 1, 0, 1);
      if (i <= 6) chk("free_stage_seq", stage, (i - 1) % N + 1);
    end
    chk("free_instr_count", ic, 2);
    chk("free_cycle_count", cc, 10);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 0, 1, 0, 1);
    chk("free_stop_idle", busy, 0);
    tick(1, 1, 0, 0, 1, 1, 0, 1);
    n = 0; k = 0;
    while (m_state == 1 && n < 20) begin
      logic f;
      f = (m_stage != MS) || (k == 2);
      if (m_stage == MS) k++;
      tick(1, 0, 0, 0, 1, f, 0, 1);
      n++;
    end
    chk("mem_wait_instr_len", n, 7);
    chk("mem_wait_stage4_len", k, 3);
    tick(1, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= T; i++) begin
      tick(1, 1, 0, 0, 0, 0, 0, 1);
      if (i == T - 1) chk("timeout_not_yet", fault, 0);
    end
    chk("timeout_fault", fault, 1);
    chk("timeout_code", fc, 1);
    for (int i = 0; i < 5; i++) tick(1, 1, 1, 1, 1, 1, 0, 1);
    chk("fault_sticky", fault, 1);
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    chk("fault_cleared", fault, 0);
    tick(1, 1, 0, 0, 1, 1, 0, 1);
    n = 0;
    while (m_stage != MS && n < 20) begin tick(1, 0, 0, 0, 1, 1, 0, 1); n++; end
    saved = ic;
    tick(1, 0, 0, 0, 1, 1, 1, 1);
    chk("err_code", fc, 2);
    chk("err_instr_unchanged", ic, saved);
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    tick(1, 1, 1, 1, 0, 1, 0, 1);
    n = 0;
    while (m_state == 1 && n < 20) begin tick(1, 1, 1, m_stage == 3, 0, 1, 0, 1); n++; end
    chk("step_one_instr", ic, 1);
    chk("step_idle", busy, 0);
    for (int i = 0; i < 3; i++) tick(1, 1, 1, 0, 0, 1, 0, 1);
    chk("step_stays_idle", stage, 0);
    tick(1, 1, 0, 0, 0, 1, 0, 1);
    tick(1, 1, 0, 0, 0, 1, 0, 1);
    tick(1, 1, 0, 0, 0, 1, 0, 1);
    chk("mid_at_stage3", stage, 3);
    tick(0, 1, 0, 0, 0, 1, 0, 1);
    chk("mid_reset_stage", stage, 0);
    chk("mid_reset_ic", ic, 0);
    chk("mid_reset_cc", cc, 0);
    for (int i = 0; i < 300; i++) tick(1, 1, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) == 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
